rfid_picc_mod_axis: RTL and testbench
=====================================

Name: rfid_picc_mod_axis

Overview:
- Parametrised PICC-to-PCD load-modulation sample generator, ISO14443A style: Manchester-coded bits carried on a subcarrier that modulates a carrier sine.
- Emits one signed sample per AXI-Stream beat on a single clock. Bit and subcarrier timing come from beat counters, not derived clocks.
- Streams unmodulated carrier when idle and frames a response on request. It is the successor to the fixed 4-byte, free-running-tvalid generator.

Parameters:
- C_M00_AXIS_TDATA_WIDTH, 32, output word width; must be >= SAMPLE_W.
- SAMPLE_W, 16, signed sine LUT sample width.
- SAMPLES_PER_CARRIER, 8, beats per carrier period; equals the LUT depth and must be a power of 2.
- ETU_CARRIERS, 128, carrier periods per bit.
- SUBC_CARRIERS, 16, carrier periods per subcarrier period; must be even and divide ETU_CARRIERS/2.
- MAX_BYTES, 8, maximum frame payload bytes.
- GAIN_W, 8, gain width; gain is Q1.(GAIN_W-1).
- FULL_GAIN, 128, unmodulated gain (1.0).
- MOD_GAIN, 96, gain while the load is switched.

Ports:
- m00_axis_aclk  in  1  sole clock.
- m00_axis_aresetn  in  1  reset, asynchronous, active-low.
- frame_data_in  in  MAX_BYTES*8  payload; byte 0 is in bits [7:0] and is sent first.
- frame_num_bytes_in  in  $clog2(MAX_BYTES+1)  payload length.
- frame_start_in  in  1  single-cycle request.
- busy_out  out  1  high from start acceptance until the last frame beat is accepted.
- done_out  out  1  one-cycle pulse after the last frame beat is accepted.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  output valid.
- m00_axis_tlast  out  1  marks the final beat of a frame.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  sign-extended sample.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  all ones whenever tvalid is high.

Behaviour:
- Reset (async assert, sync release): tvalid=0, tlast=0, tdata=0, tstrb=0, busy_out=0, done_out=0, carrier phase=0, FSM=IDLE.
- Handshake:
  - tvalid rises on the 2nd clock edge after reset release and then stays high; the stream is continuous.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - The output register reloads in the same cycle as an accept, giving 1 beat/cycle throughput.
- Timing: every counter (carrier phase, carrier count, bit-beat count) advances only on an accept.
- Sample generation:
  - sample = (sine[phase] * $signed({1'b0,gain})) >>> (GAIN_W-1), sign-extended to TDATA width.
  - phase wraps modulo SAMPLES_PER_CARRIER.
- Bit encoding:
  - A bit lasts ETU_CARRIERS*SAMPLES_PER_CARRIER beats.
  - Logic 1 is modulated in the first half-bit; logic 0 in the second half-bit.
  - Inside a modulated half-bit, gain=MOD_GAIN for the first SUBC_CARRIERS/2 carriers of each subcarrier period and FULL_GAIN for the rest.
  - Unmodulated half-bits and IDLE use FULL_GAIN.
- FSM states: IDLE -> SOF -> DATA -> PARITY -> (DATA | EOF) -> IDLE.
  - SOF: one logic-1 bit.
  - DATA: 8 bits, LSB first.
  - PARITY: odd parity over the preceding byte.
  - EOF: one unmodulated bit. tlast=1 on its final beat only.
  - After EOF: done_out pulses and the FSM returns to IDLE.
- Start acceptance:
  - frame_start_in is sampled only in IDLE with frame_num_bytes_in != 0.
  - On acceptance, data and length are latched and busy_out rises next cycle.
  - The first SOF beat is the beat loaded at the first accept strictly after the start cycle. Carrier phase continues without reset.
- Ignored or clamped requests:
  - Start while busy: ignored, no side effects.
  - Length 0: ignored, no busy or done.
  - Length > MAX_BYTES: clamped to MAX_BYTES.
- Reset mid-frame: aborts immediately to reset values; no done_out.

Optional Feature:
- Macro RFID_MOD_PARITY_EN.
- Defined: the PARITY state is present, as above.
- Undefined: PARITY is skipped; DATA chains directly to the next byte or to EOF, and frame length is (num_bytes*8+2) bits.

Decomposition:
- Package rfid_mod_pkg holds:
  - the FSM state enum (IDLE, SOF, DATA, PARITY, EOF);
  - localparams BEATS_PER_BIT and BEATS_PER_HALF_SUBC;
  - an odd-parity function.
- One sub-module, rfid_sine_lut:
  - combinational, indexed by phase;
  - SAMPLES_PER_CARRIER entries, SAMPLE_W wide;
  - amplitude 2^(SAMPLE_W-1)-1.

Test Plan (SAMPLES_PER_CARRIER=4, ETU_CARRIERS=8, SUBC_CARRIERS=2, MAX_BYTES=4, parity enabled, so 32 beats/bit):
- Reset, tready=1, no start -> tvalid high from the 2nd edge; samples repeat with period 4 at FULL_GAIN; tlast never asserted.
- Start with 1 byte 0x01 -> 352 beats (11 bits). SOF beats 0-15 alternate 4 beats MOD_GAIN/4 beats full, beats 16-31 full. Bit 0 modulated in the first half; bits 1-7 in the second half. Parity=0 is modulated in the second half. tlast only on beat 352; done_out pulses once.
- Same frame with a random tready (50% duty) -> the accepted-beat sequence is identical to the previous case; tdata and tlast are stable during every stall.
- Start with length 0, then length 7 with bytes 0x24,0x90,0x67,0x35 -> the first is ignored; the second is clamped to 4 bytes = 38 bits = 1216 beats, with tlast on the final beat.
- Second start pulse mid-frame, then aresetn low mid-frame -> the pulse is ignored; reset asynchronously clears tvalid, busy_out and tlast; no done_out; the next frame after release is correct.
- Build without RFID_MOD_PARITY_EN, 1 byte -> 10 bits = 320 beats; no parity bit present.

Source files
------------

// File: rtl/rfid_mod_pkg.sv
// rfid_mod_pkg
// Shared definitions for the PICC load-modulation sample generator:
//   - rfid_state_e       : frame FSM states
//   - BEATS_PER_BIT /
//     BEATS_PER_HALF_SUBC: beat counts for the nominal configuration
//                          (8 samples/carrier, 128 carriers/bit, 16 carriers/subcarrier)
//   - beats_per_bit(), beats_per_half_subc(): the same quantities for any parameter set
//   - odd_parity()       : parity bit that makes byte+parity carry an odd number of ones
package rfid_mod_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_PARITY,
        ST_EOF
    } rfid_state_e;

    localparam int unsigned BEATS_PER_BIT       = 8 * 128;
    localparam int unsigned BEATS_PER_HALF_SUBC = 8 * 16 / 2;

    function automatic int unsigned beats_per_bit(input int unsigned spc, input int unsigned etu);
        return spc * etu;
    endfunction

    function automatic int unsigned beats_per_half_subc(input int unsigned spc, input int unsigned subc);
        return spc * subc / 2;
    endfunction

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/rfid_sine_lut.sv
// rfid_sine_lut
// Combinational one-period sine table, amplitude 2^(SAMPLE_W-1)-1, rounded to nearest.
// Ports:
//   phase_in   : table index, 0 .. SAMPLES_PER_CARRIER-1
//   sample_out : signed sample sin(2*pi*phase/SAMPLES_PER_CARRIER)
module rfid_sine_lut #(
    parameter int unsigned SAMPLE_W            = 16,
    parameter int unsigned SAMPLES_PER_CARRIER = 8,
    parameter int unsigned PHASE_W             = $clog2(SAMPLES_PER_CARRIER)
) (
    input  logic        [PHASE_W-1:0]  phase_in,
    output logic signed [SAMPLE_W-1:0] sample_out
);

    logic signed [SAMPLE_W-1:0] lut_w [SAMPLES_PER_CARRIER];

    for (genvar i = 0; i < SAMPLES_PER_CARRIER; i++) begin : g_lut
        localparam real ANGLE = 2.0 * 3.14159265358979323846 * i / SAMPLES_PER_CARRIER;
        localparam real AMP   = (2.0 ** (SAMPLE_W - 1)) - 1.0;
        localparam real RAW   = $sin(ANGLE) * AMP;
        localparam int  VAL   = (RAW >= 0.0) ? $rtoi(RAW + 0.5) : -$rtoi(0.5 - RAW);
        assign lut_w[i] = SAMPLE_W'(VAL);
    end

    assign sample_out = lut_w[phase_in];

endmodule

// File: rtl/rfid_picc_mod_axis.sv
// rfid_picc_mod_axis
// ISO14443A-style PICC load-modulation sample generator on an AXI-Stream master.
// A continuous stream of carrier samples is emitted (one per accepted beat); on request a
// frame (SOF, bytes LSB first with optional odd parity, EOF) is Manchester-coded onto a
// subcarrier that switches the carrier gain between FULL_GAIN and MOD_GAIN.
// Ports:
//   m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//   frame_data_in      : payload, byte 0 in [7:0] sent first
//   frame_num_bytes_in : payload length (0 ignored, > MAX_BYTES clamped)
//   frame_start_in     : single-cycle start request, taken only when idle
//   busy_out           : start accepted .. last frame beat accepted
//   done_out           : one-cycle pulse after the last frame beat is accepted
//   m00_axis_*         : AXI-Stream master, tdata = sign-extended sample
// Build option: define RFID_MOD_PARITY_EN to send an odd-parity bit after every byte.
module rfid_picc_mod_axis
    import rfid_mod_pkg::*;
#(
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned SAMPLE_W               = 16,
    parameter int unsigned SAMPLES_PER_CARRIER    = 8,
    parameter int unsigned ETU_CARRIERS           = 128,
    parameter int unsigned SUBC_CARRIERS          = 16,
    parameter int unsigned MAX_BYTES              = 8,
    parameter int unsigned GAIN_W                 = 8,
    parameter int unsigned FULL_GAIN              = 128,
    parameter int unsigned MOD_GAIN               = 96
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_aresetn,
    input  logic [MAX_BYTES*8-1:0]              frame_data_in,
    input  logic [$clog2(MAX_BYTES+1)-1:0]      frame_num_bytes_in,
    input  logic                                frame_start_in,
    output logic                                busy_out,
    output logic                                done_out,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

    localparam int unsigned PHASE_W   = $clog2(SAMPLES_PER_CARRIER);
    localparam int unsigned BIT_BEATS = beats_per_bit(SAMPLES_PER_CARRIER, ETU_CARRIERS);
    localparam int unsigned HALF_BIT  = BIT_BEATS / 2;
    localparam int unsigned HSUBC     = beats_per_half_subc(SAMPLES_PER_CARRIER, SUBC_CARRIERS);
    localparam int unsigned BEAT_W    = $clog2(BIT_BEATS);
    localparam int unsigned LEN_W     = $clog2(MAX_BYTES + 1);
    localparam int unsigned IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int unsigned PROD_W    = SAMPLE_W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(FULL_GAIN);
    localparam logic [GAIN_W-1:0] GAIN_MOD  = GAIN_W'(MOD_GAIN);

    rfid_state_e                       state_q, state_d;
    logic        [PHASE_W-1:0]         phase_q, phase_d;
    logic        [BEAT_W-1:0]          beat_q, beat_d;
    logic        [2:0]                 bit_idx_q, bit_idx_d;
    logic        [IDX_W-1:0]           byte_idx_q, byte_idx_d;
    logic        [IDX_W-1:0]           last_idx_q, last_idx_d;
    logic        [MAX_BYTES*8-1:0]     data_q, data_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              started_q, started_d;
    logic                              tvalid_q, tvalid_d;
    logic                              tlast_q, tlast_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;

    logic                       load, accept, start_ok, bit_end, first_half, mod_half, subc_on;
    logic        [7:0]          cur_byte;
    logic        [GAIN_W-1:0]   gain;
    logic signed [SAMPLE_W-1:0] lut_sample;
    logic signed [PROD_W-1:0]   prod, scaled;
    logic        [LEN_W-1:0]    len_clamped, len_m1;

    rfid_sine_lut #(
        .SAMPLE_W            (SAMPLE_W),
        .SAMPLES_PER_CARRIER (SAMPLES_PER_CARRIER),
        .PHASE_W             (PHASE_W)
    ) u_lut (
        .phase_in   (phase_q),
        .sample_out (lut_sample)
    );

    always_comb begin
        // The output register loads the beat described by the current counters and then
        // advances them; after the very first load every load coincides with an accept.
        load     = started_q && (!tvalid_q || m00_axis_tready);
        accept   = tvalid_q && m00_axis_tready;
        start_ok = frame_start_in && (state_q == ST_IDLE) && !busy_q && (frame_num_bytes_in != '0);

        cur_byte   = data_q[{byte_idx_q, 3'b000} +: 8];
        bit_end    = (32'(beat_q) == BIT_BEATS - 1);
        first_half = (32'(beat_q) < HALF_BIT);
        // The half-bit is a whole number of subcarrier periods, so the subcarrier
        // position follows from the beat count within the bit.
        subc_on    = (((32'(beat_q) / HSUBC) % 2) == 0);

        case (state_q)
            ST_SOF:    mod_half = first_half;
            ST_DATA:   mod_half = cur_byte[bit_idx_q] ? first_half : !first_half;
            ST_PARITY: mod_half = odd_parity(cur_byte) ? first_half : !first_half;
            default:   mod_half = 1'b0;
        endcase

        gain   = (mod_half && subc_on) ? GAIN_MOD : GAIN_FULL;
        prod   = PROD_W'(lut_sample) * PROD_W'($signed({1'b0, gain}));
        scaled = prod >>> (GAIN_W - 1);

        len_clamped = (frame_num_bytes_in > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : frame_num_bytes_in;
        len_m1      = len_clamped - 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        beat_d     = beat_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        last_idx_d = last_idx_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        started_d  = 1'b1;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = C_M00_AXIS_TDATA_WIDTH'(scaled);
            tlast_d  = (state_q == ST_EOF) && bit_end;
            phase_d  = phase_q + 1'b1;
            if (state_q != ST_IDLE) begin
                beat_d = bit_end ? '0 : beat_q + 1'b1;
                if (bit_end) begin
                    case (state_q)
                        ST_SOF: state_d = ST_DATA;
                        ST_DATA: begin
                            if (bit_idx_q == 3'd7) begin
                                bit_idx_d = '0;
`ifdef RFID_MOD_PARITY_EN
                                state_d = ST_PARITY;
`else
                                if (byte_idx_q == last_idx_q) state_d = ST_EOF;
                                else byte_idx_d = byte_idx_q + 1'b1;
`endif
                            end else begin
                                bit_idx_d = bit_idx_q + 1'b1;
                            end
                        end
                        ST_PARITY: begin
                            if (byte_idx_q == last_idx_q) begin
                                state_d = ST_EOF;
                            end else begin
                                state_d    = ST_DATA;
                                byte_idx_d = byte_idx_q + 1'b1;
                            end
                        end
                        ST_EOF:  state_d = ST_IDLE;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        end

        // The FSM is back in IDLE once the EOF tail is loaded, but busy holds until
        // that beat is actually taken downstream.
        if (accept && tlast_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (start_ok) begin
            state_d    = ST_SOF;
            beat_d     = '0;
            bit_idx_d  = '0;
            byte_idx_d = '0;
            last_idx_d = len_m1[IDX_W-1:0];
            data_d     = frame_data_in;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            beat_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            last_idx_q <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            started_q  <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            beat_q     <= beat_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            last_idx_q <= last_idx_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            started_q  <= started_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
        end
    end

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){tvalid_q}};

endmodule

// File: tb/tb_rfid_picc_mod_axis.sv
// tb_rfid_picc_mod_axis
// Self-checking bench for rfid_picc_mod_axis in a small configuration
// (4 samples/carrier, 8 carriers/bit, 2 carriers/subcarrier, 4 bytes max -> 32 beats/bit).
// The reference model works per accepted beat: beat n carries carrier phase n mod 4, and
// a frame is a list of bit values whose gain pattern follows the Manchester rules.
module tb_rfid_picc_mod_axis;

    localparam int unsigned TDW  = 32;
    localparam int unsigned MAXB = 4;
    localparam int unsigned SPC  = 4;
    localparam int unsigned ETU  = 8;
    localparam int unsigned SUBC = 2;
    localparam int BEATS_BIT     = SPC * ETU;
`ifdef RFID_MOD_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [MAXB*8-1:0] frame_data_in      = '0;
    logic [2:0]       frame_num_bytes_in = '0;
    logic             frame_start_in     = 1'b0;
    logic             busy_out, done_out;
    logic             m00_axis_tready    = 1'b1;
    logic             m00_axis_tvalid, m00_axis_tlast;
    logic [TDW-1:0]   m00_axis_tdata;
    logic [TDW/8-1:0] m00_axis_tstrb;

    rfid_picc_mod_axis #(
        .C_M00_AXIS_TDATA_WIDTH (TDW),
        .SAMPLE_W               (16),
        .SAMPLES_PER_CARRIER    (SPC),
        .ETU_CARRIERS           (ETU),
        .SUBC_CARRIERS          (SUBC),
        .MAX_BYTES              (MAXB),
        .GAIN_W                 (8),
        .FULL_GAIN              (128),
        .MOD_GAIN               (96)
    ) dut (
        .m00_axis_aclk      (clk),
        .m00_axis_aresetn   (rst_n),
        .frame_data_in      (frame_data_in),
        .frame_num_bytes_in (frame_num_bytes_in),
        .frame_start_in     (frame_start_in),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .m00_axis_tready    (m00_axis_tready),
        .m00_axis_tvalid    (m00_axis_tvalid),
        .m00_axis_tlast     (m00_axis_tlast),
        .m00_axis_tdata     (m00_axis_tdata),
        .m00_axis_tstrb     (m00_axis_tstrb)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // reference model state
    int          m_edges;     // clock edges since reset release
    int          acc_cnt;     // beats accepted since reset release
    bit          m_busy, m_done, m_cur_last;
    int          frame_base;  // accepted-beat index of the first SOF beat
    int          bits[$];     // frame bit values: 0, 1, or 2 for the unmodulated EOF
    logic [39:0] exp_vec;     // {tvalid, tlast, tstrb[3:0], busy, done, tdata[31:0]}

    function automatic int sine_ref(input int ph);
        case (ph)
            0:       return 0;
            1:       return 32767;
            2:       return 0;
            default: return -32767;
        endcase
    endfunction

    function automatic int frame_gain(input int k);
        int b   = bits[k / BEATS_BIT];
        int pos = k % BEATS_BIT;
        bit modh;
        modh = (b == 1 && pos < BEATS_BIT / 2) || (b == 0 && pos >= BEATS_BIT / 2);
        if (modh && ((pos / (SPC * SUBC / 2)) % 2 == 0)) return 96;
        return 128;
    endfunction

    task automatic build_frame(input logic [31:0] data, input int n);
        logic [7:0] b;
        bits.delete();
        bits.push_back(1);
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            for (int j = 0; j < 8; j++) bits.push_back(int'(b[j]));
            if (PAR_BITS != 0) bits.push_back((^b) ? 0 : 1);
        end
        bits.push_back(2);
    endtask

    task automatic model_reset();
        m_edges = 0; acc_cnt = 0; m_busy = 0; m_done = 0; m_cur_last = 0; frame_base = 0;
        bits.delete();
    endtask

    task automatic compute_expect();
        int gain = 128;
        int smp;
        int k;
        bit last = 0;
        if (m_edges < 2) begin
            exp_vec = '0;
        end else begin
            if (m_busy && acc_cnt >= frame_base) begin
                k    = acc_cnt - frame_base;
                gain = frame_gain(k);
                last = (k == bits.size() * BEATS_BIT - 1);
            end
            smp     = (sine_ref(acc_cnt % SPC) * gain) >>> 7;
            exp_vec = {1'b1, last, 4'hF, m_busy, m_done, smp[31:0]};
        end
        m_cur_last = last;
    endtask

    // Called at a falling edge: drives inputs, advances the model across the next rising
    // edge, and returns at the following falling edge with exp_vec updated.
    task automatic drive_cycle(input bit rdy, input bit st, input logic [31:0] data, input logic [2:0] nb);
        bit acc;
        int n;
        m00_axis_tready    = rdy;
        frame_start_in     = st;
        frame_data_in      = data;
        frame_num_bytes_in = nb;
        acc    = (m_edges >= 2) && rdy;
        m_done = 0;
        if (acc) acc_cnt++;
        if (acc && m_cur_last) begin
            m_busy = 0;
            m_done = 1;
        end else if (st && !m_busy && nb != 0) begin
            n = (nb > MAXB) ? MAXB : int'(nb);
            build_frame(data, n);
            m_busy     = 1;
            frame_base = acc_cnt + 1;
        end
        m_edges++;
        @(posedge clk);
        @(negedge clk);
        compute_expect();
    endtask

    // Runs one start request to completion; exp_bits = 0 means the request must be ignored.
    task automatic run_frame(input string name, input logic [31:0] data, input logic [2:0] nb,
                             input bit rnd, input int exp_bits);
        int cnt = 0, dones = 0, post = 0;
        bit rdy;
        for (int cyc = 0; cyc < 8000 && post < 4; cyc++) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy_out && m00_axis_tvalid && rdy) cnt++;
            drive_cycle(rdy, cyc == 0, data, nb);
            n_total++;
            if ({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata} !== exp_vec)
                $display("FAIL %s beat %0d: got %h expected %h", name, acc_cnt,
                         {m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata}, exp_vec);
            else n_pass++;
            if (done_out) dones++;
            if (!m_busy) post++;
        end
        n_total++;
        if (m_busy) $display("FAIL %s_timeout: frame still running, required to finish", name);
        else n_pass++;
        // one idle beat is already presented when the start is taken and is accepted while busy
        n_total++;
        if (cnt != ((exp_bits == 0) ? 0 : exp_bits * BEATS_BIT + 1))
            $display("FAIL %s_beats: got %0d accepted while busy, required %0d", name, cnt,
                     (exp_bits == 0) ? 0 : exp_bits * BEATS_BIT + 1);
        else n_pass++;
        n_total++;
        if (dones != ((exp_bits == 0) ? 0 : 1))
            $display("FAIL %s_done: got %0d done pulses, required %0d", name, dones, (exp_bits == 0) ? 0 : 1);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata} !== 40'h0)
                $display("FAIL reset_values: got %h required 0",
                         {m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata});
            else n_pass++;
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, 1'b0, '0, '0);
            n_total++;
            if ({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata} !== exp_vec)
                $display("FAIL idle_carrier cycle %0d: got %h expected %h", i,
                         {m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata}, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_frame_single();
        run_frame("frame01", 32'h0000_0001, 3'd1, 1'b0, 8 + 2 + PAR_BITS);
    endtask

    task automatic test_frame_stall();
        run_frame("frame01_stall", 32'h0000_0001, 3'd1, 1'b1, 8 + 2 + PAR_BITS);
    endtask

    task automatic test_len0_and_clamp();
        run_frame("len0", 32'hFFFF_FFFF, 3'd0, 1'b0, 0);
        run_frame("clamp", 32'h3567_9024, 3'd7, 1'b1, MAXB * (8 + PAR_BITS) + 2);
    endtask

    task automatic test_restart_and_reset();
        bit rdy;
        int n;
        logic [31:0] d;
        for (int cyc = 0; cyc < 200; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            drive_cycle(rdy, (cyc == 0) || (cyc == 80),
                        (cyc == 0) ? 32'hA5C3_0F11 : 32'h1234_5678, (cyc == 0) ? 3'd3 : 3'd2);
            n_total++;
            if ({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata} !== exp_vec)
                $display("FAIL restart_ignored beat %0d: got %h expected %h", acc_cnt,
                         {m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata}, exp_vec);
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata} !== 40'h0)
            $display("FAIL async_reset: got %h required 0",
                     {m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({busy_out, done_out, m00_axis_tvalid} !== 3'b000)
                $display("FAIL reset_hold: got busy/done/tvalid %b required 000", {busy_out, done_out, m00_axis_tvalid});
            else n_pass++;
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, '0, '0);
            n_total++;
            if ({m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata} !== exp_vec)
                $display("FAIL post_reset_idle cycle %0d: got %h expected %h", i,
                         {m00_axis_tvalid, m00_axis_tlast, m00_axis_tstrb, busy_out, done_out, m00_axis_tdata}, exp_vec);
            else n_pass++;
        end
        n = $urandom_range(1, MAXB);
        d = $urandom;
        run_frame("post_reset_frame", d, 3'(n), 1'b1, n * (8 + PAR_BITS) + 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        compute_expect();
        test_reset();
        test_frame_single();
        test_frame_stall();
        test_len0_and_clamp();
        test_restart_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
